// File: rtl/apsr_cond_unit.sv
// APSR NZCV flag register and Thumb ITSTATE with the execute-stage condition check.
// exec_en is combinational on the registered flags/ITSTATE and gates every flag write.
module apsr_cond_unit (
   input  logic       clk,
   input  logic       rst,
   input  logic       alu_neg,
   input  logic       alu_zero,
   input  logic       alu_c_out,
   input  logic       alu_ovfl,
   input  logic       nz_we,
   input  logic       c_we,
   input  logic       v_we,
   input  logic [3:0] instr_cond,
   input  logic       instr_valid,
   input  logic       instr_retire,
   input  logic       it_start,
   input  logic [3:0] it_firstcond,
   input  logic [3:0] it_mask,
   input  logic       itstate_load,
   input  logic [7:0] itstate_in,
   output logic [3:0] flags,
   output logic [7:0] itstate,
   output logic       in_it,
   output logic       exec_en
);

   localparam int unsigned FLAG_W = 4;
   localparam int unsigned IT_W   = 8;
   localparam int unsigned COND_W = 4;

   logic [FLAG_W-1:0] flags_q, flags_d;
   logic [IT_W-1:0]   itstate_q, itstate_d;
   logic [COND_W-1:0] eff_cond;
   logic              flag_n, flag_z, flag_c, flag_v;
   logic              cond_pass;

   assign flag_n = flags_q[3];
   assign flag_z = flags_q[2];
   assign flag_c = flags_q[1];
   assign flag_v = flags_q[0];

   assign in_it    = |itstate_q[3:0];
   assign eff_cond = in_it ? itstate_q[7:4] : instr_cond;

   // Condition evaluation on the architectural flags
   always_comb begin
      cond_pass = 1'b1;
      case (eff_cond)
         4'h0:    cond_pass = flag_z;
         4'h1:    cond_pass = ~flag_z;
         4'h2:    cond_pass = flag_c;
         4'h3:    cond_pass = ~flag_c;
         4'h4:    cond_pass = flag_n;
         4'h5:    cond_pass = ~flag_n;
         4'h6:    cond_pass = flag_v;
         4'h7:    cond_pass = ~flag_v;
         4'h8:    cond_pass = flag_c & ~flag_z;
         4'h9:    cond_pass = ~flag_c | flag_z;
         4'hA:    cond_pass = (flag_n == flag_v);
         4'hB:    cond_pass = (flag_n != flag_v);
         4'hC:    cond_pass = ~flag_z & (flag_n == flag_v);
         4'hD:    cond_pass = flag_z | (flag_n != flag_v);
         default: cond_pass = 1'b1;
      endcase
   end

   assign exec_en = instr_valid & cond_pass;

   always_comb begin
      flags_d = flags_q;
      if (exec_en && nz_we) begin
         flags_d[3] = alu_neg;
         flags_d[2] = alu_zero;
      end
      if (exec_en && c_we) flags_d[1] = alu_c_out;
      if (exec_en && v_we) flags_d[0] = alu_ovfl;
   end

   // ITSTATE: restore > IT start > advance on retire; advance ignores the condition result
   always_comb begin
      itstate_d = itstate_q;
      if (itstate_load) begin
         itstate_d = itstate_in;
      end else if (it_start) begin
         if (it_mask != 4'h0) itstate_d = {it_firstcond, it_mask};
         else                 itstate_d = IT_W'(0);
      end else if (instr_retire && in_it) begin
         if (itstate_q[2:0] == 3'b000) itstate_d = IT_W'(0);
         else                          itstate_d = {itstate_q[7:5], itstate_q[3:0], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags_q   <= FLAG_W'(0);
         itstate_q <= IT_W'(0);
      end else begin
         flags_q   <= flags_d;
         itstate_q <= itstate_d;
      end
   end

   assign flags   = flags_q;
   assign itstate = itstate_q;

endmodule

// File: tb/tb_apsr_cond_unit.sv
// Directed plus random checks of apsr_cond_unit against an architectural reference model.
module tb_apsr_cond_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       alu_neg, alu_zero, alu_c_out, alu_ovfl;
   logic       nz_we, c_we, v_we;
   logic [3:0] instr_cond;
   logic       instr_valid, instr_retire;
   logic       it_start;
   logic [3:0] it_firstcond, it_mask;
   logic       itstate_load;
   logic [7:0] itstate_in;
   logic [3:0] flags;
   logic [7:0] itstate;
   logic       in_it, exec_en;

   int errors = 0;
   int checks = 0;

   // reference state
   bit       m_n, m_z, m_c, m_v;
   bit [7:0] m_it;

   apsr_cond_unit dut (
      .clk(clk), .rst(rst),
      .alu_neg(alu_neg), .alu_zero(alu_zero), .alu_c_out(alu_c_out), .alu_ovfl(alu_ovfl),
      .nz_we(nz_we), .c_we(c_we), .v_we(v_we),
      .instr_cond(instr_cond), .instr_valid(instr_valid), .instr_retire(instr_retire),
      .it_start(it_start), .it_firstcond(it_firstcond), .it_mask(it_mask),
      .itstate_load(itstate_load), .itstate_in(itstate_in),
      .flags(flags), .itstate(itstate), .in_it(in_it), .exec_en(exec_en)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ARM pseudo-code style: base test from cond[3:1], inverted by cond[0] except for AL
   function automatic bit cond_ok(input bit [3:0] c, input bit n, input bit z, input bit cf, input bit v);
      bit r;
      case (c[3:1])
         3'd0: r = z;
         3'd1: r = cf;
         3'd2: r = n;
         3'd3: r = v;
         3'd4: r = cf && !z;
         3'd5: r = (n == v);
         3'd6: r = !z && (n == v);
         default: r = 1'b1;
      endcase
      if (c[0] && c[3:1] != 3'd7) r = !r;
      return r;
   endfunction

   task automatic idle();
      {alu_neg, alu_zero, alu_c_out, alu_ovfl} = 4'b0;
      {nz_we, c_we, v_we} = 3'b0;
      instr_cond = 4'h0; instr_valid = 1'b0; instr_retire = 1'b0;
      it_start = 1'b0; it_firstcond = 4'h0; it_mask = 4'h0;
      itstate_load = 1'b0; itstate_in = 8'h00;
   endtask

   task automatic model_reset();
      {m_n, m_z, m_c, m_v} = 4'b0;
      m_it = 8'h00;
   endtask

   // Check the combinational outputs, clock once, then check the registered state
   task automatic step(input string tag);
      bit       en, m_in;
      bit [3:0] ec;
      #2;
      m_in = (m_it[3:0] != 4'h0);
      ec   = m_in ? m_it[7:4] : instr_cond;
      en   = instr_valid && cond_ok(ec, m_n, m_z, m_c, m_v);
      chk({tag, ".exec_en"}, 8'(exec_en), 8'(en));
      chk({tag, ".in_it"}, 8'(in_it), 8'(m_in));
      if (en && nz_we) begin m_n = alu_neg; m_z = alu_zero; end
      if (en && c_we) m_c = alu_c_out;
      if (en && v_we) m_v = alu_ovfl;
      if (itstate_load)                  m_it = itstate_in;
      else if (it_start)                 m_it = (it_mask != 0) ? {it_firstcond, it_mask} : 8'h00;
      else if (instr_retire && m_in)     m_it = (m_it % 8 == 0) ? 8'h00 : ((m_it & 8'hE0) | ((m_it * 2) & 8'h1F));
      @(posedge clk);
      #1;
      chk({tag, ".flags"}, 8'(flags), 8'({m_n, m_z, m_c, m_v}));
      chk({tag, ".itstate"}, itstate, m_it);
   endtask

   initial begin
      idle();
      model_reset();
      rst = 1'b1;
      #12 rst = 1'b0;
      chk("rst.flags", 8'(flags), 8'h00);
      chk("rst.itstate", itstate, 8'h00);

      instr_valid = 1'b1; instr_cond = 4'h0;
      #1 chk("rst.eq_fails", 8'(exec_en), 8'h0);
      instr_cond = 4'hE;
      #1 chk("rst.al_passes", 8'(exec_en), 8'h1);

      // SUBS 5-5: N0 Z1 C1 V0
      {alu_neg, alu_zero, alu_c_out, alu_ovfl} = 4'b0110;
      {nz_we, c_we, v_we} = 3'b111;
      step("sub");
      chk("sub.flags0110", 8'(flags), 8'h06);
      idle(); instr_valid = 1'b1;
      instr_cond = 4'h0; #1 chk("sub.eq", 8'(exec_en), 8'h1);
      instr_cond = 4'h2; #1 chk("sub.cs", 8'(exec_en), 8'h1);
      instr_cond = 4'h9; #1 chk("sub.ls", 8'(exec_en), 8'h1);
      instr_cond = 4'h8; #1 chk("sub.hi", 8'(exec_en), 8'h0);

      // ITTE EQ with Z=1
      idle(); it_start = 1'b1; it_firstcond = 4'h0; it_mask = 4'h6; instr_retire = 1'b1;
      step("itte");
      chk("itte.it06", itstate, 8'h06);
      chk("itte.in_it", 8'(in_it), 8'h1);
      idle(); instr_valid = 1'b1; instr_retire = 1'b1; instr_cond = 4'h1;
      step("itte.i1");
      chk("itte.it0c", itstate, 8'h0C);
      step("itte.i2");
      chk("itte.it18", itstate, 8'h18);
      #2 chk("itte.i3_ne_fails", 8'(exec_en), 8'h0);
      step("itte.i3");
      chk("itte.it00", itstate, 8'h00);

      // Clear Z, then the first IT instruction fails and must not write flags
      idle(); instr_valid = 1'b1; instr_cond = 4'hE; nz_we = 1'b1;
      step("clrz");
      idle(); it_start = 1'b1; it_mask = 4'h6;
      step("itte2");
      idle(); instr_valid = 1'b1; instr_retire = 1'b1; nz_we = 1'b1; alu_zero = 1'b1;
      #1 chk("supp.exec_en", 8'(exec_en), 8'h0);
      step("supp");
      chk("supp.flags", 8'(flags), 8'h02);
      chk("supp.it0c", itstate, 8'h0C);

      idle(); it_start = 1'b1; it_firstcond = 4'hA; it_mask = 4'h8; instr_retire = 1'b1;
      step("restart");
      chk("restart.itA8", itstate, 8'hA8);
      idle(); itstate_load = 1'b1; itstate_in = 8'h46; it_start = 1'b1; it_mask = 4'h3;
      step("load");
      chk("load.it46", itstate, 8'h46);

      // Set up itstate=0x0C, flags=1111, then assert reset between edges
      idle(); itstate_load = 1'b1; itstate_in = 8'h00;
      step("ld0");
      idle(); instr_valid = 1'b1; instr_cond = 4'hE;
      {alu_neg, alu_zero, alu_c_out, alu_ovfl} = 4'b1111; {nz_we, c_we, v_we} = 3'b111;
      step("f1111");
      idle(); itstate_load = 1'b1; itstate_in = 8'h0C;
      step("ld0c");
      idle();
      #2 rst = 1'b1;
      #1;
      chk("arst.flags", 8'(flags), 8'h00);
      chk("arst.itstate", itstate, 8'h00);
      #1 rst = 1'b0;
      model_reset();
      itstate_load = 1'b1; itstate_in = 8'h46;
      step("ld46");
      idle(); it_start = 1'b1; it_firstcond = 4'h5; it_mask = 4'h0;
      step("badmask");
      chk("badmask.it00", itstate, 8'h00);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         {alu_neg, alu_zero, alu_c_out, alu_ovfl} = 4'($urandom);
         {nz_we, c_we, v_we} = 3'($urandom);
         instr_cond   = 4'($urandom);
         instr_valid  = ($urandom_range(3) != 0);
         instr_retire = ($urandom_range(1) != 0);
         it_start     = ($urandom_range(7) == 0);
         it_firstcond = 4'($urandom);
         it_mask      = 4'($urandom);
         itstate_load = ($urandom_range(15) == 0);
         itstate_in   = 8'($urandom);
         step("rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
